// File: rtl/sap_datapath.sv
// SAP-1 style datapath: PC, MAR, IR, A, B, flags, RAM, ALU and display on one shared bus.
// Executes the sequencer's control word on the falling clock edge; the IR opcode nibble goes back as `command`.
module sap_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       ctrl_wrd,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        command,
  output logic [DATA_W-1:0] bus_dbg,
  output logic [DATA_W-1:0] disp,
  output logic              disp_stb,
  output logic              carry_f,
  output logic              zero_f,
  output logic              halted,
  output logic              bus_conflict
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned SUM_W = DATA_W + 1;

  localparam int unsigned B_HLT  = 15;
  localparam int unsigned B_AI   = 14;
  localparam int unsigned B_AO   = 13;
  localparam int unsigned B_BI   = 12;
  localparam int unsigned B_MI   = 11;
  localparam int unsigned B_RR   = 10;
  localparam int unsigned B_RW   = 9;
  localparam int unsigned B_II   = 8;
  localparam int unsigned B_IO   = 7;
  localparam int unsigned B_CI   = 6;
  localparam int unsigned B_CO   = 5;
  localparam int unsigned B_CE   = 4;
  localparam int unsigned B_SUB  = 3;
  localparam int unsigned B_ALUO = 2;
  localparam int unsigned B_DI   = 1;
  localparam int unsigned B_FL   = 0;

  logic hlt, ai, ao, bi, mi, rr, rw, ii, io, ci, co, ce, sub, aluo, di, fl;

  assign hlt  = ctrl_wrd[B_HLT];
  assign ai   = ctrl_wrd[B_AI];
  assign ao   = ctrl_wrd[B_AO];
  assign bi   = ctrl_wrd[B_BI];
  assign mi   = ctrl_wrd[B_MI];
  assign rr   = ctrl_wrd[B_RR];
  assign rw   = ctrl_wrd[B_RW];
  assign ii   = ctrl_wrd[B_II];
  assign io   = ctrl_wrd[B_IO];
  assign ci   = ctrl_wrd[B_CI];
  assign co   = ctrl_wrd[B_CO];
  assign ce   = ctrl_wrd[B_CE];
  assign sub  = ctrl_wrd[B_SUB];
  assign aluo = ctrl_wrd[B_ALUO];
  assign di   = ctrl_wrd[B_DI];
  assign fl   = ctrl_wrd[B_FL];

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] bus;
  logic [SUM_W-1:0]  alu_sum;
  logic              multi_drv;
  logic              upd;
  logic [DATA_W-1:0] ram [DEPTH];

  // Subtraction is A + ~B + 1, so the carry out reads as "no borrow".
  always_comb begin
    alu_sum = {1'b0, a} + {1'b0, b};
    if (sub) begin
      alu_sum = {1'b0, a} + {1'b0, ~b} + SUM_W'(1);
    end
  end

  // Fixed-priority bus source select.
  always_comb begin
    bus = '0;
    if (rr)        bus = ram[mar];
    else if (io)   bus = DATA_W'(ir[3:0]);
    else if (co)   bus = DATA_W'(pc);
    else if (aluo) bus = alu_sum[DATA_W-1:0];
    else if (ao)   bus = a;
  end

  assign multi_drv = $countones({rr, io, co, aluo, ao}) > 1;
  // The halting word itself commits nothing besides the halt.
  assign upd       = !halted && !hlt;
  assign bus_dbg   = bus;
  assign command   = ir[DATA_W-1 -: 4];

  // RAM: program load while in reset, otherwise RW at the pre-edge MAR.
  always_ff @(negedge CLK) begin
    if (RST) begin
      if (prog_we) ram[prog_addr] <= prog_data;
    end else if (upd && rw) begin
      ram[mar] <= bus;
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      pc           <= '0;
      mar          <= '0;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      disp         <= '0;
      disp_stb     <= 1'b0;
      carry_f      <= 1'b0;
      zero_f       <= 1'b0;
      halted       <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      disp_stb <= upd && di;
      if (!halted && multi_drv) bus_conflict <= 1'b1;
      if (!halted && hlt)       halted       <= 1'b1;
      if (upd) begin
        if (ai) a   <= bus;
        if (bi) b   <= bus;
        if (mi) mar <= bus[ADDR_W-1:0];
        if (ii) ir  <= bus;
        if (di) disp <= bus;
        if (ci)      pc <= bus[ADDR_W-1:0];
        else if (ce) pc <= pc + ADDR_W'(1);
        if (fl) begin
          carry_f <= alu_sum[DATA_W];
          zero_f  <= (alu_sum[DATA_W-1:0] == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench for sap_datapath: directed scenarios plus randomized control words
// checked against a behavioural model of the datapath.
module tb_sap_datapath;

  localparam logic [15:0] HLT  = 16'h8000;
  localparam logic [15:0] AI   = 16'h4000;
  localparam logic [15:0] AO   = 16'h2000;
  localparam logic [15:0] BI   = 16'h1000;
  localparam logic [15:0] MI   = 16'h0800;
  localparam logic [15:0] RR   = 16'h0400;
  localparam logic [15:0] RW   = 16'h0200;
  localparam logic [15:0] II   = 16'h0100;
  localparam logic [15:0] IO   = 16'h0080;
  localparam logic [15:0] CI   = 16'h0040;
  localparam logic [15:0] CO   = 16'h0020;
  localparam logic [15:0] CE   = 16'h0010;
  localparam logic [15:0] SUB  = 16'h0008;
  localparam logic [15:0] ALUO = 16'h0004;
  localparam logic [15:0] DI   = 16'h0002;
  localparam logic [15:0] FL   = 16'h0001;

  logic        CLK;
  logic        RST;
  logic [15:0] ctrl_wrd;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  command;
  logic [7:0]  bus_dbg;
  logic [7:0]  disp;
  logic        disp_stb;
  logic        carry_f;
  logic        zero_f;
  logic        halted;
  logic        bus_conflict;

  int n_pass  = 0;
  int n_total = 0;

  sap_datapath dut (
    .CLK(CLK), .RST(RST), .ctrl_wrd(ctrl_wrd),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .command(command), .bus_dbg(bus_dbg), .disp(disp), .disp_stb(disp_stb),
    .carry_f(carry_f), .zero_f(zero_f), .halted(halted), .bus_conflict(bus_conflict)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Behavioural model state
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_a, m_b, m_disp;
  logic       m_stb, m_cf, m_zf, m_halt, m_conf;
  logic [7:0] m_ram [16];

  logic [3:0] pa [$];
  logic [7:0] pd [$];

  function automatic bit has(input logic [15:0] cw, input logic [15:0] m);
    return (cw & m) != 16'h0;
  endfunction

  function automatic logic [7:0] m_bus(input logic [15:0] cw);
    int s;
    if (has(cw, RR)) return m_ram[m_mar];
    if (has(cw, IO)) return {4'h0, m_ir[3:0]};
    if (has(cw, CO)) return {4'h0, m_pc};
    if (has(cw, ALUO)) begin
      s = has(cw, SUB) ? int'(m_a) - int'(m_b) : int'(m_a) + int'(m_b);
      return 8'(s);
    end
    if (has(cw, AO)) return m_a;
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_disp = 0;
    m_stb = 0; m_cf = 0; m_zf = 0; m_halt = 0; m_conf = 0;
  endtask

  task automatic m_apply(input logic [15:0] cw);
    logic [7:0] bv;
    int s, nd;
    bit c;
    bv = m_bus(cw);
    s  = has(cw, SUB) ? int'(m_a) - int'(m_b) : int'(m_a) + int'(m_b);
    c  = has(cw, SUB) ? (m_a >= m_b) : (s > 255);
    nd = int'(has(cw, RR)) + int'(has(cw, IO)) + int'(has(cw, CO)) +
         int'(has(cw, ALUO)) + int'(has(cw, AO));
    if (!m_halt && nd > 1) m_conf = 1;
    m_stb = 0;
    if (m_halt) return;
    if (has(cw, HLT)) begin
      m_halt = 1;
      return;
    end
    if (has(cw, RW)) m_ram[m_mar] = bv;
    if (has(cw, AI)) m_a = bv;
    if (has(cw, BI)) m_b = bv;
    if (has(cw, MI)) m_mar = bv[3:0];
    if (has(cw, II)) m_ir = bv;
    if (has(cw, DI)) begin m_disp = bv; m_stb = 1; end
    if (has(cw, CI)) m_pc = bv[3:0];
    else if (has(cw, CE)) m_pc = m_pc + 4'd1;
    if (has(cw, FL)) begin m_cf = c; m_zf = (8'(s) == 8'h00); end
  endtask

  // One sequencer cycle: word applied at posedge, bus sampled mid-phase, committed at negedge.
  task automatic cyc(input logic [15:0] cw, output logic [7:0] seen);
    @(posedge CLK);
    ctrl_wrd = cw;
    #1 seen = bus_dbg;
    @(negedge CLK);
    m_apply(cw);
    #1;
  endtask

  task automatic poke(input logic [3:0] ad, input logic [7:0] d);
    pa.push_back(ad);
    pd.push_back(d);
  endtask

  // Reset, then load the queued RAM image while reset is held.
  task automatic reset_load();
    @(posedge CLK);
    #1 RST = 1'b1;
    ctrl_wrd = 16'h0;
    m_reset();
    while (pa.size() > 0) begin
      prog_we = 1'b1;
      prog_addr = pa.pop_front();
      prog_data = pd.pop_front();
      @(negedge CLK);
      m_ram[prog_addr] = prog_data;
      #1;
    end
    prog_we = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic set_ab(input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] s;
    poke(4'h0, 8'h0E); poke(4'h1, 8'h0F); poke(4'hE, av); poke(4'hF, bv);
    reset_load();
    cyc(CO | MI, s); cyc(RR | II | CE, s); cyc(IO | MI, s); cyc(RR | AI, s);
    cyc(CO | MI, s); cyc(RR | II | CE, s); cyc(IO | MI, s); cyc(RR | BI, s);
  endtask

  task automatic test_reset();
    logic [7:0] s;
    #3 RST = 1'b1;
    #1;
    n_total++;
    if ({disp, disp_stb, carry_f, zero_f, halted, bus_conflict, command} !== 16'h0)
      $display("FAIL reset_outputs: got disp=%h stb=%b c=%b z=%b h=%b bc=%b cmd=%h want all 0",
               disp, disp_stb, carry_f, zero_f, halted, bus_conflict, command);
    else n_pass++;
    m_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
    cyc(CO, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL reset_pc: got %h want 00", s); else n_pass++;
    cyc(AO, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL reset_a: got %h want 00", s); else n_pass++;
  endtask

  task automatic test_program();
    logic [7:0] s;
    int stbs = 0;
    poke(4'h0, 8'h1E); poke(4'h1, 8'h2F); poke(4'h2, 8'h30); poke(4'h3, 8'h90);
    poke(4'h4, 8'hA0); poke(4'hE, 8'h05); poke(4'hF, 8'h03);
    reset_load();
    for (int k = 0; k < 10 && !halted; k++) begin
      cyc(CO | MI, s);
      cyc(RR | II | CE, s);
      n_total++;
      if (command !== m_ir[7:4]) $display("FAIL prog_cmd: got %h want %h", command, m_ir[7:4]);
      else n_pass++;
      case (command)
        4'h1: begin cyc(IO | MI, s); cyc(RR | AI, s); end
        4'h2: begin cyc(IO | MI, s); cyc(RR | BI, s); cyc(ALUO | AI | FL, s); end
        4'h3: begin cyc(IO | MI, s); cyc(AO | RW, s); end
        4'h9: begin cyc(AO | DI, s); if (disp_stb) stbs++; cyc(16'h0, s); end
        4'hA: cyc(HLT, s);
        default: cyc(16'h0, s);
      endcase
      if (disp_stb) stbs++;
    end
    n_total++;
    if (halted !== 1'b1) $display("FAIL prog_halted: got %b want 1", halted); else n_pass++;
    n_total++;
    if (disp !== 8'h08) $display("FAIL prog_disp: got %h want 08", disp); else n_pass++;
    n_total++;
    if (stbs !== 1) $display("FAIL prog_stb_pulses: got %0d want 1", stbs); else n_pass++;
    n_total++;
    if ({carry_f, zero_f} !== 2'b00) $display("FAIL prog_flags: got %b%b want 00", carry_f, zero_f);
    else n_pass++;
    cyc(CO, s);
    n_total++;
    if (s !== 8'h05) $display("FAIL prog_pc: got %h want 05", s); else n_pass++;
  endtask

  task automatic test_alu();
    logic [7:0] s, av, bv, ea;
    bit sb, ec;
    int r;
    set_ab(8'h05, 8'h07);
    cyc(SUB | ALUO | AI | FL, s);
    cyc(AO, s);
    n_total++;
    if ({s, carry_f, zero_f} !== {8'hFE, 2'b00})
      $display("FAIL alu_sub_neg: got A=%h c=%b z=%b want A=fe c=0 z=0", s, carry_f, zero_f);
    else n_pass++;
    set_ab(8'h05, 8'h05);
    cyc(SUB | ALUO | AI | FL, s);
    cyc(AO, s);
    n_total++;
    if ({s, carry_f, zero_f} !== {8'h00, 2'b11})
      $display("FAIL alu_sub_zero: got A=%h c=%b z=%b want A=00 c=1 z=1", s, carry_f, zero_f);
    else n_pass++;
    for (int i = 0; i < 24; i++) begin
      av = 8'($urandom); bv = 8'($urandom); sb = 1'($urandom);
      if (i == 0) begin av = 8'hFF; bv = 8'h01; sb = 0; end
      r  = sb ? int'(av) - int'(bv) : int'(av) + int'(bv);
      ea = 8'(r);
      ec = sb ? (av >= bv) : (r > 255);
      set_ab(av, bv);
      cyc((sb ? SUB : 16'h0) | ALUO | AI | FL, s);
      cyc(AO, s);
      n_total++;
      if ({s, carry_f, zero_f} !== {ea, ec, ea == 8'h00})
        $display("FAIL alu_rand: %h %s %h got A=%h c=%b z=%b want A=%h c=%b z=%b",
                 av, sb ? "-" : "+", bv, s, carry_f, zero_f, ea, ec, ea == 8'h00);
      else n_pass++;
      cyc(ALUO | BI, s);
      n_total++;
      if ({carry_f, zero_f} !== {ec, ea == 8'h00})
        $display("FAIL alu_noflag_hold: got c=%b z=%b want c=%b z=%b",
                 carry_f, zero_f, ec, ea == 8'h00);
      else n_pass++;
    end
  endtask

  task automatic test_pc();
    logic [7:0] s;
    poke(4'h0, 8'h8C);
    reset_load();
    cyc(CO | MI, s);
    cyc(RR | II, s);
    n_total++;
    if (command !== 4'h8) $display("FAIL pc_command: got %h want 8", command); else n_pass++;
    repeat (15) cyc(CE, s);
    cyc(CO, s);
    n_total++;
    if (s !== 8'h0F) $display("FAIL pc_count15: got %h want 0f", s); else n_pass++;
    cyc(CE, s);
    cyc(CO, s);
    n_total++;
    if (s !== 8'h00) $display("FAIL pc_wrap: got %h want 00", s); else n_pass++;
    repeat (15) cyc(CE, s);
    cyc(CE | CI | IO, s);
    cyc(CO, s);
    n_total++;
    if (s !== 8'h0C) $display("FAIL pc_ci_wins: got %h want 0c", s); else n_pass++;
  endtask

  task automatic test_conflict();
    logic [7:0] s;
    poke(4'h0, 8'h5B);
    reset_load();
    cyc(RR | AO | MI, s);
    n_total++;
    if (s !== 8'h5B) $display("FAIL conflict_bus: got %h want 5b", s); else n_pass++;
    n_total++;
    if (bus_conflict !== 1'b1) $display("FAIL conflict_set: got %b want 1", bus_conflict);
    else n_pass++;
    repeat (3) cyc(16'h0, s);
    n_total++;
    if (bus_conflict !== 1'b1) $display("FAIL conflict_sticky: got %b want 1", bus_conflict);
    else n_pass++;
    reset_load();
    n_total++;
    if (bus_conflict !== 1'b0) $display("FAIL conflict_rst: got %b want 0", bus_conflict);
    else n_pass++;
  endtask

  task automatic test_halt();
    logic [7:0] s;
    set_ab(8'h33, 8'h11);
    cyc(HLT | AI | AO, s);
    n_total++;
    if (halted !== 1'b1) $display("FAIL halt_set: got %b want 1", halted); else n_pass++;
    cyc(AI | CO, s); cyc(CE, s); cyc(RW | CO, s); cyc(DI | AO, s); cyc(RR | AO | CO, s);
    cyc(AO, s);
    n_total++;
    if (s !== 8'h33) $display("FAIL halt_a: got %h want 33", s); else n_pass++;
    cyc(CO, s);
    n_total++;
    if (s !== 8'h02) $display("FAIL halt_pc: got %h want 02", s); else n_pass++;
    cyc(RR, s);
    n_total++;
    if (s !== 8'h11) $display("FAIL halt_ram: got %h want 11", s); else n_pass++;
    n_total++;
    if ({disp, disp_stb, bus_conflict} !== 10'h0)
      $display("FAIL halt_disp: got disp=%h stb=%b bc=%b want 0", disp, disp_stb, bus_conflict);
    else n_pass++;
    reset_load();
    n_total++;
    if (halted !== 1'b0) $display("FAIL halt_rst: got %b want 0", halted); else n_pass++;
  endtask

  task automatic test_guards();
    logic [7:0] s;
    poke(4'h0, 8'h03); poke(4'h3, 8'h5A);
    reset_load();
    prog_we = 1'b1; prog_addr = 4'h3; prog_data = 8'hAA;
    cyc(CO | MI, s); cyc(RR | II | CE, s); cyc(IO | MI, s); cyc(RR | AI, s);
    n_total++;
    if (s !== 8'h5A) $display("FAIL progwe_ignored: got %h want 5a", s); else n_pass++;
    prog_we = 1'b0;
    @(posedge CLK);
    ctrl_wrd = CO | MI;
    #1 RST = 1'b1;
    ctrl_wrd = AO;
    #1;
    n_total++;
    if (bus_dbg !== 8'h00) $display("FAIL midrst_a: got %h want 00", bus_dbg); else n_pass++;
    ctrl_wrd = CO;
    #1;
    n_total++;
    if (bus_dbg !== 8'h00) $display("FAIL midrst_pc: got %h want 00", bus_dbg); else n_pass++;
    ctrl_wrd = IO;
    #1;
    n_total++;
    if ({bus_dbg, command} !== 12'h0)
      $display("FAIL midrst_ir: got io=%h cmd=%h want 0", bus_dbg, command);
    else n_pass++;
    m_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
    ctrl_wrd = 16'h0;
  endtask

  task automatic test_random();
    logic [7:0] s, eb;
    logic [15:0] cw;
    for (int i = 0; i < 16; i++) poke(4'(i), 8'($urandom));
    reset_load();
    for (int i = 0; i < 200; i++) begin
      cw = 16'($urandom) & 16'h5B5B;
      case ($urandom_range(0, 6))
        0: ;
        1: cw |= RR;
        2: cw |= IO;
        3: cw |= CO;
        4: cw |= ALUO;
        5: cw |= AO;
        default: cw |= 16'($urandom) & (RR | IO | CO | ALUO | AO);
      endcase
      eb = m_bus(cw);
      cyc(cw, s);
      n_total++;
      if (s !== eb) $display("FAIL rand_bus: cw=%h got %h want %h", cw, s, eb); else n_pass++;
      n_total++;
      if ({disp, disp_stb, carry_f, zero_f, bus_conflict, command} !==
          {m_disp, m_stb, m_cf, m_zf, m_conf, m_ir[7:4]})
        $display("FAIL rand_state: cw=%h got %h %b %b %b %b %h want %h %b %b %b %b %h", cw,
                 disp, disp_stb, carry_f, zero_f, bus_conflict, command,
                 m_disp, m_stb, m_cf, m_zf, m_conf, m_ir[7:4]);
      else n_pass++;
    end
  endtask

  initial begin
    RST = 1'b0;
    ctrl_wrd = 16'h0;
    prog_we = 1'b0;
    prog_addr = 4'h0;
    prog_data = 8'h00;
    test_reset();
    test_program();
    test_alu();
    test_pc();
    test_conflict();
    test_halt();
    test_guards();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
